// File: rtl/mul_if.sv
// mul_if -- request/response bundle for the iterative multiplier.
//   start_i        : request a multiply (sampled only while the unit is idle)
//   op_i[1:0]      : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   multiplicand_i : operand A (rs1), 32 bits
//   multiplier_i   : operand B (rs2), 32 bits
//   reg_waddr_i    : destination register tag, 5 bits
//   result_o       : selected 32-bit product word, held until the next result
//   ready_o        : one-cycle pulse, result_o/reg_waddr_o valid
//   busy_o         : an operation is in flight
//   reg_waddr_o    : tag latched at start, returned with the result
// The master modport is the requester (execute stage); the slave is mul.
interface mul_if;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] multiplicand_i;
    logic [31:0] multiplier_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic [4:0]  reg_waddr_o;

    modport master (
        output start_i, op_i, multiplicand_i, multiplier_i, reg_waddr_i,
        input  result_o, ready_o, busy_o, reg_waddr_o
    );

    modport slave (
        input  start_i, op_i, multiplicand_i, multiplier_i, reg_waddr_i,
        output result_o, ready_o, busy_o, reg_waddr_o
    );
endinterface

// File: rtl/mul.sv
// mul -- 32x32 radix-2 shift-add multiplier, fixed 35-cycle throughput.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mul_if.slave (request operands/op/tag, response result/ready/busy/tag)
// Operands are converted to magnitudes up front, multiplied unsigned one
// multiplier bit per cycle (LSB first), and the 64-bit product is negated in
// a single adjust cycle when exactly one signed operand was negative.
// Outputs are registered, so ready_o rises in the cycle after the DONE edge.
module mul (
    input  logic  clk,
    input  logic  rst,
    mul_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        ADJ  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t      state_q,  state_d;
    logic [1:0]  op_q,     op_d;
    logic [4:0]  tag_q,    tag_d;
    logic        neg_q,    neg_d;
    logic [63:0] mcand_q,  mcand_d;
    logic [31:0] mplr_q,   mplr_d;
    logic [63:0] acc_q,    acc_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [31:0] result_q, result_d;
    logic        ready_q,  ready_d;
    logic        busy_q,   busy_d;
    logic [4:0]  waddr_q,  waddr_d;

    logic        sign_a_s;
    logic        sign_b_s;

    // Magnitude of a 32-bit value; 0x80000000 maps to itself read as unsigned.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // Operand sign bits that count: A is signed unless MULHU, B only for MUL/MULH.
    always_comb begin
        sign_a_s = bus.multiplicand_i[31] & (bus.op_i != 2'b11);
        sign_b_s = bus.multiplier_i[31]   & ~bus.op_i[1];
    end

    // Next-state and datapath/output update logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tag_d    = tag_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ready_d  = 1'b0;
        waddr_d  = waddr_q;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    op_d    = bus.op_i;
                    tag_d   = bus.reg_waddr_i;
                    neg_d   = sign_a_s ^ sign_b_s;
                    mcand_d = {32'd0, magnitude(bus.multiplicand_i, sign_a_s)};
                    mplr_d  = magnitude(bus.multiplier_i, sign_b_s);
                    acc_d   = 64'd0;
                    cnt_d   = 5'd0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // Shifted multiplicand is added when the current multiplier LSB is set.
                if (mplr_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d = {mcand_q[62:0], 1'b0};
                mplr_d  = {1'b0, mplr_q[31:1]};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ADJ;
                end else begin
                    state_d = CALC;
                end
            end
            ADJ: begin
                if (neg_q) begin
                    acc_d = ~acc_q + 64'd1;
                end else begin
                    acc_d = acc_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (op_q == 2'b00) begin
                    result_d = acc_q[31:0];
                end else begin
                    result_d = acc_q[63:32];
                end
                ready_d = 1'b1;
                waddr_d = tag_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            tag_q    <= 5'd0;
            neg_q    <= 1'b0;
            mcand_q  <= 64'd0;
            mplr_q   <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            waddr_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            waddr_q  <= waddr_d;
        end
    end

    assign bus.result_o    = result_q;
    assign bus.ready_o     = ready_q;
    assign bus.busy_o      = busy_q;
    assign bus.reg_waddr_o = waddr_q;
endmodule
